memory_request_queue: RTL and testbench
=======================================

# memory_request_queue

Request buffer and issue sequencer directly upstream of the memory control FSM. It accepts load/store requests from the execute stage through a valid/ready handshake and holds them in a small FIFO. It issues them one at a time as single-cycle `load`/`store` pulses with a stable `word_type`, `is_signed_fsm`, address and write data. It retires each request on the FSM's completion pulse and returns a registered response (load data or store acknowledge) to the pipeline.

## Interface
- `DEPTH`, 2, FIFO entries; power of two, ≥2.
- `ADDR_W`, 32, address width.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  queue can accept; `= !full`.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_word_type`  in  2  `10` word, `01` halfword, `00` byte, `11` illegal.
- `req_is_signed`  in  1  sign-extend loads.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data.
- `load`, `store`  out  1 each  one-cycle issue pulses to the FSM.
- `word_type`  out  2  head-entry word type.
- `is_signed_fsm`  out  1  head-entry signedness.
- `mem_addr`  out  ADDR_W  head-entry address.
- `mem_wdata`  out  32  head-entry store data.
- `busy`  in  1  FSM busy.
- `output_valid`  in  1  FSM load completion.
- `write_ready`  in  1  FSM store completion.
- `mem_rdata`  in  32  assembled load data; valid while `output_valid` is high.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_is_store`  out  1  response belongs to a store.
- `rsp_error`  out  1  request aborted (illegal type or timeout).
- `rsp_data`  out  32  load data; 0 for stores and errors.
- `pending`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Circular FIFO with read/write pointers plus an occupancy counter. The pointers wrap modulo `DEPTH`.
- Push when `req_valid && req_ready`. There is no bypass: a pop does not free a slot for a push in the same cycle, so a full queue deasserts `req_ready` even while it is popping.
- Head-entry fields drive `word_type`, `is_signed_fsm`, `mem_addr` and `mem_wdata` continuously. These outputs stay stable from issue until pop.
- Issue FSM states: `Q_IDLE`, `Q_ISSUE`, `Q_WAIT`.
  - `Q_IDLE`, queue not empty, `!busy`, head type legal → `Q_ISSUE`.
  - `Q_IDLE`, queue not empty, head type `11` → pop, error response, stay in `Q_IDLE`. Nothing is issued.
  - `Q_ISSUE`: assert `load` (or `store`) for exactly one cycle, then go to `Q_WAIT`.
  - `Q_WAIT`: load waits for `output_valid`; store waits for `write_ready`. On completion: pop, register the response, go to `Q_IDLE`. A completion signal of the wrong kind is ignored.
- Load response: `rsp_data <= mem_rdata`, `rsp_is_store=0`. Store response: `rsp_data=0`, `rsp_is_store=1`.
- Reset (asynchronous, active-low) clears pointers, counter and state, and drops any in-flight request. All outputs go to 0, except the head-field outputs, which read the cleared storage (0).

## Timing
- Push at cycle 0 → `load`/`store` pulse at cycle 2 (`Q_ISSUE`); the FSM reacts from cycle 3.
- Byte or halfword load / halfword store: completion at cycle 3, `rsp_valid` at cycle 4.
- Word load/store and byte store: completion at cycle 4, `rsp_valid` at cycle 5.
- Back-to-back requests: the next issue pulse comes 2 cycles after the prior completion, because the FSM must return to IDLE with `busy=0`.
- Illegal-type entry: popped and `rsp_valid`+`rsp_error` asserted the cycle after it reaches the head in `Q_IDLE`.
- `rsp_valid` is a single-cycle pulse with no backpressure; the consumer must accept it.
- `pending` updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.

## Configuration
- `MEM_REQ_TIMEOUT_EN` defined: a 4-bit watchdog counts cycles spent in `Q_WAIT`. At 15 cycles without completion, the queue pops the head, raises `rsp_valid` with `rsp_error=1` and `rsp_data=0`, and returns to `Q_IDLE`.
- Undefined: no watchdog; `Q_WAIT` waits indefinitely. `rsp_error` is asserted only for illegal types.

## Test plan
- Signed byte load, addr 0x10, model FSM returns 0xFFFFFF80 → `load` pulse at cycle 2; `rsp_valid` at cycle 4 with `rsp_data=0xFFFFFF80`, `rsp_is_store=0`.
- Word store, wdata 0xDEADBEEF, then a word load pushed back-to-back → second `load` pulse exactly 2 cycles after `write_ready`; `mem_wdata` is stable at 0xDEADBEEF throughout the store.
- Push 3 requests with DEPTH=2 and the FSM stalled → `req_ready=0` after 2 pushes and `pending=2`; the third request is accepted the cycle after the first pop.
- `req_word_type=11` → no `load`/`store` pulse; one `rsp_valid` with `rsp_error=1`, `rsp_data=0`.
- Assert `reset` low mid-`Q_WAIT` of a word load → all outputs go to 0 immediately; `pending=0`; no response is produced after release.
- With `MEM_REQ_TIMEOUT_EN` and the FSM never completing → `rsp_error=1` pulse 15 cycles after entry to `Q_WAIT`; the next queued request then issues.

Source files
------------

// File: rtl/memory_request_queue.sv
// Load/store request FIFO + one-at-a-time issue sequencer for the memory FSM; optional watchdog via MEM_REQ_TIMEOUT_EN.
// Latency: push->issue pulse 2 cycles; response registered 1 cycle after FSM completion (or after illegal head).
// Backpressure: req_ready = !full (no same-cycle pop bypass); responses are single-cycle pulses with no backpressure.
module memory_request_queue #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_is_store,
    input  logic [1:0]                 req_word_type,
    input  logic                       req_is_signed,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [31:0]                req_wdata,
    output logic                       load,
    output logic                       store,
    output logic [1:0]                 word_type,
    output logic                       is_signed_fsm,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       busy,
    input  logic                       output_valid,
    input  logic                       write_ready,
    input  logic [31:0]                mem_rdata,
    output logic                       rsp_valid,
    output logic                       rsp_is_store,
    output logic                       rsp_error,
    output logic [31:0]                rsp_data,
    output logic [$clog2(DEPTH):0]     pending
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              is_store;
        logic [1:0]        wtype;
        logic              is_signed;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } entry_t;

    typedef enum logic [1:0] {Q_IDLE, Q_ISSUE, Q_WAIT} state_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    state_t             state_q;
    logic               load_q, store_q;
    logic               rsp_valid_q, rsp_is_store_q, rsp_error_q;
    logic [31:0]        rsp_data_q;

    entry_t head;
    logic   empty, full, push, pop, head_illegal, done, timeout;

    assign head         = mem_q[rd_ptr_q];
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    // Held low while reset is asserted so every control output reads 0 during reset.
    assign req_ready    = reset & ~full;
    assign push         = req_valid & req_ready;
    assign head_illegal = (head.wtype == 2'b11);
    assign done         = (state_q == Q_WAIT) && (head.is_store ? write_ready : output_valid);
    assign pop          = ((state_q == Q_IDLE) && !empty && head_illegal) || done || timeout;

`ifdef MEM_REQ_TIMEOUT_EN
    logic [3:0] wdog_q;
    assign timeout = (state_q == Q_WAIT) && !done && (wdog_q == 4'd14);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
        end else if (state_q == Q_WAIT) begin
            wdog_q <= wdog_q + 4'd1;
        end else begin
            wdog_q <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{is_store:  req_is_store,
                                     wtype:     req_word_type,
                                     is_signed: req_is_signed,
                                     addr:      req_addr,
                                     wdata:     req_wdata};
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= Q_IDLE;
            load_q         <= 1'b0;
            store_q        <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_is_store_q <= 1'b0;
            rsp_error_q    <= 1'b0;
            rsp_data_q     <= '0;
        end else begin
            load_q         <= 1'b0;
            store_q        <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_is_store_q <= 1'b0;
            rsp_error_q    <= 1'b0;
            rsp_data_q     <= '0;
            case (state_q)
                Q_IDLE: begin
                    if (!empty) begin
                        if (head_illegal) begin
                            rsp_valid_q    <= 1'b1;
                            rsp_error_q    <= 1'b1;
                            rsp_is_store_q <= head.is_store;
                        end else if (!busy) begin
                            state_q <= Q_ISSUE;
                            load_q  <= ~head.is_store;
                            store_q <= head.is_store;
                        end
                    end
                end
                Q_ISSUE: state_q <= Q_WAIT;
                Q_WAIT: begin
                    if (done) begin
                        state_q        <= Q_IDLE;
                        rsp_valid_q    <= 1'b1;
                        rsp_is_store_q <= head.is_store;
                        rsp_data_q     <= head.is_store ? 32'd0 : mem_rdata;
                    end else if (timeout) begin
                        state_q        <= Q_IDLE;
                        rsp_valid_q    <= 1'b1;
                        rsp_error_q    <= 1'b1;
                        rsp_is_store_q <= head.is_store;
                    end
                end
                default: state_q <= Q_IDLE;
            endcase
        end
    end

    assign load          = load_q;
    assign store         = store_q;
    assign word_type     = head.wtype;
    assign is_signed_fsm = head.is_signed;
    assign mem_addr      = head.addr;
    assign mem_wdata     = head.wdata;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_is_store  = rsp_is_store_q;
    assign rsp_error     = rsp_error_q;
    assign rsp_data      = rsp_data_q;
    assign pending       = count_q;
endmodule

// File: tb/tb_memory_request_queue.sv
// Bench for memory_request_queue: behavioural memory-FSM model plus a response scoreboard.
module tb_memory_request_queue;
    localparam int DEPTH  = 2;
    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_is_store = 1'b0, req_is_signed = 1'b0;
    logic [1:0]  req_word_type = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        busy = 1'b0, output_valid = 1'b0, write_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        req_ready, load, store, is_signed_fsm, rsp_valid, rsp_is_store, rsp_error;
    logic [1:0]  word_type;
    logic [31:0] mem_addr, mem_wdata, rsp_data;
    logic [1:0]  pending;

    memory_request_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_word_type(req_word_type), .req_is_signed(req_is_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .load(load), .store(store), .word_type(word_type), .is_signed_fsm(is_signed_fsm),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .output_valid(output_valid), .write_ready(write_ready), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_is_store(rsp_is_store), .rsp_error(rsp_error),
        .rsp_data(rsp_data), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        st;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   pulse_q[$], done_q[$], rsp_q[$];
    int   cyc = 0, n_tests = 0, n_fail = 0, rsp_cnt = 0;
    logic seen_load = 1'b0, seen_store = 1'b0, in_store = 1'b0;
    logic [1:0] seen_wt = 2'b00, pulse_wt = 2'b00;
    logic pulse_signed = 1'b0;
    logic fsm_hold = 1'b0, chk_wd = 1'b0;
    logic [31:0] exp_wd = '0;
    int   drop_n = 0, m_remain = 0;
    logic m_store = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a == 32'h10) return 32'hFFFF_FF80;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic int model_lat(input logic [1:0] wt, input logic st);
        if (wt == 2'b10) return 2;
        if (st && wt == 2'b00) return 2;
        return 1;
    endfunction

    always @(posedge clk) cyc++;

    // Memory FSM model: reacts the cycle after an issue pulse, completes after 1 or 2 cycles.
    always @(posedge clk) begin
        #1;
        output_valid = 1'b0;
        write_ready  = 1'b0;
        mem_rdata    = '0;
        if (!reset) m_remain = 0;
        if (fsm_hold) begin
            busy = 1'b1;
        end else begin
            if (seen_load || seen_store) begin
                if (drop_n > 0) begin
                    drop_n--;
                end else begin
                    m_store  = seen_store;
                    m_remain = model_lat(seen_wt, seen_store);
                end
            end
            if (m_remain > 0) begin
                m_remain--;
                busy = 1'b1;
                if (m_remain == 0) begin
                    if (m_store) write_ready = 1'b1;
                    else begin
                        output_valid = 1'b1;
                        mem_rdata    = model_rd(mem_addr);
                    end
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        seen_load  = load;
        seen_store = store;
        seen_wt    = word_type;
        if (load || store) begin
            pulse_q.push_back(cyc);
            pulse_signed = is_signed_fsm;
            pulse_wt     = word_type;
            if (store) in_store = 1'b1;
        end
        if (chk_wd && in_store) chk("mem_wdata_stable", 64'(mem_wdata), 64'(exp_wd));
        if (output_valid || write_ready) done_q.push_back(cyc);
        if (write_ready) in_store = 1'b0;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_q.push_back(cyc);
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("rsp_is_store", 64'(rsp_is_store), 64'(e.st));
                chk("rsp_error", 64'(rsp_error), 64'(e.err));
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
            end
        end
    end

    task automatic push_req(input logic st, input logic [1:0] wt, input logic sg,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic exp_err, output int acc);
        exp_t e;
        acc           = -1;
        req_valid     = 1'b1;
        req_is_store  = st;
        req_word_type = wt;
        req_is_signed = sg;
        req_addr      = addr;
        req_wdata     = wd;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc    = cyc;
                e.st   = st;
                e.err  = exp_err || (wt == 2'b11);
                e.data = (e.err || st) ? 32'd0 : model_rd(addr);
                sb.push_back(e);
                break;
            end
        end
        if (acc < 0) chk("push_accept", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic to_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic clr_logs();
        pulse_q.delete();
        done_q.delete();
        rsp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int p, p2, p3, saved;
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_load", 64'(load), 64'(0));
        chk("rst_store", 64'(store), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_pending", 64'(pending), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_req_ready", 64'(req_ready), 64'(1));

        // Signed byte load
        clr_logs();
        push_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, p);
        @(negedge clk);
        chk("t1_pending", 64'(pending), 64'(1));
        drain();
        chk("t1_pulse_cyc", 64'(pulse_q[0]), 64'(p + 2));
        chk("t1_pulse_signed", 64'(pulse_signed), 64'(1));
        chk("t1_pulse_wt", 64'(pulse_wt), 64'(0));
        chk("t1_rsp_cyc", 64'(rsp_q[0]), 64'(p + 4));
        chk("t1_pending_end", 64'(pending), 64'(0));

        // Word store then back-to-back word load
        clr_logs();
        exp_wd = 32'hDEAD_BEEF;
        chk_wd = 1'b1;
        push_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 1'b0, p);
        push_req(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 1'b0, p2);
        drain();
        chk_wd = 1'b0;
        chk("t2_store_pulse", 64'(pulse_q[0]), 64'(p + 2));
        chk("t2_store_done", 64'(done_q[0]), 64'(p + 4));
        chk("t2_store_rsp", 64'(rsp_q[0]), 64'(p + 5));
        chk("t2_load_pulse", 64'(pulse_q[1]), 64'(done_q[0] + 2));
        chk("t2_load_rsp", 64'(rsp_q[1]), 64'(done_q[1] + 1));

        // Full queue with stalled FSM
        clr_logs();
        fsm_hold = 1'b1;
        @(posedge clk);
        #1;
        push_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 1'b0, p);
        push_req(1'b1, 2'b00, 1'b0, 32'h34, 32'h55, 1'b0, p2);
        @(negedge clk);
        chk("t3_pending_full", 64'(pending), 64'(2));
        chk("t3_ready_full", 64'(req_ready), 64'(0));
        fsm_hold = 1'b0;
        push_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0, p3);
        chk("t3_third_accept", 64'(p3), 64'(done_q[0] + 1));
        drain();
        chk("t3_pulses", 64'(pulse_q.size()), 64'(3));

        // Illegal word type
        clr_logs();
        push_req(1'b0, 2'b11, 1'b0, 32'h50, 32'h0, 1'b1, p);
        drain();
        repeat (4) @(negedge clk);
        chk("t4_no_pulse", 64'(pulse_q.size()), 64'(0));
        chk("t4_rsp_cyc", 64'(rsp_q[0]), 64'(p + 2));
        chk("t4_rsp_count", 64'(rsp_q.size()), 64'(1));

        // Reset during Q_WAIT of a word load
        clr_logs();
        drop_n = 1;
        push_req(1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 1'b0, p);
        to_cyc(p + 4);
        reset = 1'b0;
        #1;
        chk("t5_load", 64'(load), 64'(0));
        chk("t5_store", 64'(store), 64'(0));
        chk("t5_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("t5_pending", 64'(pending), 64'(0));
        chk("t5_mem_addr", 64'(mem_addr), 64'(0));
        chk("t5_word_type", 64'(word_type), 64'(0));
        sb.delete();
        drop_n = 0;
        saved = rsp_cnt;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_no_rsp", 64'(rsp_cnt), 64'(saved));
        chk("t5_pulse_once", 64'(pulse_q.size()), 64'(1));
        @(posedge clk);
        #1;

`ifdef MEM_REQ_TIMEOUT_EN
        // Watchdog: FSM ignores the first issue
        clr_logs();
        drop_n = 1;
        push_req(1'b0, 2'b10, 1'b0, 32'h70, 32'h0, 1'b1, p);
        push_req(1'b1, 2'b10, 1'b0, 32'h74, 32'h1234, 1'b0, p2);
        drain();
        chk("t6_timeout_rsp", 64'(rsp_q[0]), 64'(p + 18));
        chk("t6_next_issue", 64'(pulse_q[1]), 64'(p + 19));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
